// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mips_muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit with HI/LO pair.   |
// | Define MIPS_MULDIV_SIGNED_EN to build signed magnitude conversion/fixup. |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic             MtHi,
    input  logic             MtLo,
    input  logic [WIDTH-1:0] Rs,
    input  logic [WIDTH-1:0] Rt,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    localparam int             CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]  C_LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [WIDTH-1:0] rs_q, rs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             dz_q, dz_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic [WIDTH:0]     sum, rem_sh, diff;

`ifdef MIPS_MULDIV_SIGNED_EN
    logic sign_a, sign_b;
    logic neg_res_q, neg_res_d;
    logic neg_rem_q, neg_rem_d;

    assign sign_a = ~Op[0] & Rs[WIDTH-1];
    assign sign_b = ~Op[0] & Rt[WIDTH-1];
    assign abs_a  = sign_a ? -Rs : Rs;
    assign abs_b  = sign_b ? -Rt : Rt;

    always_comb begin
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        if (state_q == S_IDLE && Start) begin
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    // Remainder follows the dividend's sign; quotient/product follow the XOR.
    assign prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;
`else
    logic unused_op0;
    assign unused_op0 = Op[0];
    assign abs_a      = Rs;
    assign abs_b      = Rt;
    assign prod_fix   = {acc_hi_q, acc_lo_q};
    assign quo_fix    = acc_lo_q;
    assign rem_fix    = acc_hi_q;
`endif

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (Start) state_d = S_CALC;
            S_CALC:  if (cnt_q == C_LAST) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        Busy = (state_q != S_IDLE);
    end

    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

    // Datapath: acc_hi/acc_lo hold product {P_hi,P_lo} or {rem,quo}.
    always_comb begin
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        mag_d    = mag_q;
        rs_d     = rs_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        sum    = {1'b0, acc_hi_q} + {1'b0, mag_q};
        rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, mag_q};

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    cnt_d    = '0;
                    is_div_d = Op[1];
                    dz_d     = Op[1] & (Rt == '0);
                    rs_d     = Rs;
                    acc_hi_d = '0;
                    acc_lo_d = Op[1] ? abs_a : abs_b;
                    mag_d    = Op[1] ? abs_b : abs_a;
                end else begin
                    if (MtHi) hi_d = Rs;
                    if (MtLo) lo_d = Rs;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) begin
                    // A clear borrow bit means the trial subtraction succeeded.
                    if (!diff[WIDTH])
                        {acc_hi_d, acc_lo_d} = {diff[WIDTH-1:0], acc_lo_q[WIDTH-2:0], 1'b1};
                    else
                        {acc_hi_d, acc_lo_d} = {rem_sh[WIDTH-1:0], acc_lo_q[WIDTH-2:0], 1'b0};
                end else if (acc_lo_q[0]) begin
                    {acc_hi_d, acc_lo_d} = {sum, acc_lo_q[WIDTH-1:1]};
                end else begin
                    {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[WIDTH-1:1]};
                end
            end
            S_FIN: begin
                done_d = 1'b1;
                if (dz_q) begin
                    hi_d = rs_q;
                    lo_d = '1;
                end else if (is_div_q) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            mag_q    <= '0;
            rs_q     <= '0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            mag_q    <= mag_d;
            rs_q     <= rs_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mips_muldiv_unit : randomized self-checking bench for mips_muldiv_unit|
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module tb_mips_muldiv_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [1:0]  Op;
    logic        MtHi;
    logic        MtLo;
    logic [31:0] Rs;
    logic [31:0] Rt;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;
    logic [31:0] specials [5];

    mips_muldiv_unit #(.WIDTH(32)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .Start (Start),
        .Op    (Op),
        .MtHi  (MtHi),
        .MtLo  (MtLo),
        .Rs    (Rs),
        .Rt    (Rt),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on sign- or zero-extended operands.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic               sgn;
        logic signed [63:0] sa, sb, sp, sq, sr;
`ifdef MIPS_MULDIV_SIGNED_EN
        sgn = ~op[0];
`else
        sgn = 1'b0;
`endif
        sa = sgn ? {{32{a[31]}}, a} : {32'b0, a};
        sb = sgn ? {{32{b[31]}}, b} : {32'b0, b};
        if (!op[1]) begin
            sp = sa * sb;
            hi = sp[63:32];
            lo = sp[31:0];
        end else if (b == 32'd0) begin
            hi = a;
            lo = 32'hFFFFFFFF;
        end else begin
            sq = sa / sb;
            sr = sa % sb;
            hi = sr[31:0];
            lo = sq[31:0];
        end
    endfunction

    task automatic do_move(input logic hi_en, input logic lo_en, input logic [31:0] val, input string tag);
        MtHi = hi_en;
        MtLo = lo_en;
        Rs   = val;
        @(posedge CLK);
        #1;
        MtHi = 1'b0;
        MtLo = 1'b0;
        if (hi_en) cur_hi = val;
        if (lo_en) cur_lo = val;
        check_eq({tag, "_hi"}, Hi, cur_hi);
        check_eq({tag, "_lo"}, Lo, cur_lo);
        check_eq({tag, "_nobusy"}, {Busy, Done}, 2'b00);
    endtask

    // dist_cyc: cycle at which Start/MtHi/MtLo are pulsed mid-op (0 = none).
    // rst_cyc: cycle after which RST is asserted (0 = none).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic mt_with_start, input int dist_cyc, input int rst_cyc,
                          input string tag);
        logic [31:0] eh, el;
        logic        window_bad;
        model(op, a, b, eh, el);
        window_bad = 1'b0;
        Start = 1'b1;
        Op    = op;
        Rs    = a;
        Rt    = b;
        MtHi  = mt_with_start;
        MtLo  = mt_with_start;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        MtHi  = 1'b0;
        MtLo  = 1'b0;
        Rs    = $urandom;
        Rt    = $urandom;
        check_eq({tag, "_busy_e0"}, Busy, 1'b1);
        check_eq({tag, "_hi_hold"}, Hi, cur_hi);
        check_eq({tag, "_lo_hold"}, Lo, cur_lo);
        for (int e = 1; e <= 33; e++) begin
            if (e == dist_cyc) begin
                Start = 1'b1;
                MtHi  = 1'b1;
                MtLo  = 1'b1;
                Op    = 2'($urandom_range(0, 3));
                Rs    = $urandom;
                Rt    = $urandom;
            end else begin
                Start = 1'b0;
                MtHi  = 1'b0;
                MtLo  = 1'b0;
            end
            @(posedge CLK);
            #1;
            if (e == rst_cyc) begin
                Start = 1'b0;
                MtHi  = 1'b0;
                MtLo  = 1'b0;
                RST   = 1'b1;
                #1;
                check_eq({tag, "_rst_hi"}, Hi, 32'd0);
                check_eq({tag, "_rst_lo"}, Lo, 32'd0);
                check_eq({tag, "_rst_busy"}, {Busy, Done}, 2'b00);
                #2;
                RST    = 1'b0;
                cur_hi = 32'd0;
                cur_lo = 32'd0;
                return;
            end
            if (e < 33 && (Busy !== 1'b1 || Done !== 1'b0)) window_bad = 1'b1;
        end
        Start = 1'b0;
        MtHi  = 1'b0;
        MtLo  = 1'b0;
        check_eq({tag, "_busy_window"}, window_bad, 1'b0);
        check_eq({tag, "_busy_end"}, Busy, 1'b0);
        check_eq({tag, "_done"}, Done, 1'b1);
        check_eq({tag, "_hi"}, Hi, eh);
        check_eq({tag, "_lo"}, Lo, el);
        cur_hi = eh;
        cur_lo = el;
        @(posedge CLK);
        #1;
        check_eq({tag, "_done_clr"}, Done, 1'b0);
    endtask

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        specials[0] = 32'h00000000;
        specials[1] = 32'h00000001;
        specials[2] = 32'hFFFFFFFF;
        specials[3] = 32'h80000000;
        specials[4] = 32'h7FFFFFFF;
        RST   = 1'b1;
        Start = 1'b0;
        MtHi  = 1'b0;
        MtLo  = 1'b0;
        Op    = 2'b00;
        Rs    = 32'd0;
        Rt    = 32'd0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check_eq("reset_hi", Hi, 32'd0);
        check_eq("reset_lo", Lo, 32'd0);
        check_eq("reset_busy", Busy, 1'b0);
        check_eq("reset_done", Done, 1'b0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        do_move(1'b1, 1'b0, 32'h12345678, "mthi");
        do_move(1'b0, 1'b1, 32'hCAFEF00D, "mtlo");
        do_move(1'b1, 1'b1, 32'h0BADBEEF, "mtboth");

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 0, "multu_max");
        check_eq("multu_max_hi_k", Hi, 32'hFFFFFFFE);
        check_eq("multu_max_lo_k", Lo, 32'h00000001);
`ifdef MIPS_MULDIV_SIGNED_EN
        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 1'b0, 0, 0, "mult_neg");
        check_eq("mult_neg_hi_k", Hi, 32'hFFFFFFFF);
        check_eq("mult_neg_lo_k", Lo, 32'hFFFFFFEB);
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, 0, 0, "div_neg");
        check_eq("div_neg_hi_k", Hi, 32'hFFFFFFFF);
        check_eq("div_neg_lo_k", Lo, 32'hFFFFFFFD);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, "div_ovf");
        check_eq("div_ovf_hi_k", Hi, 32'd0);
        check_eq("div_ovf_lo_k", Lo, 32'h80000000);
`else
        run_op(2'b00, 32'hFFFFFFFF, 32'd2, 1'b0, 0, 0, "mult_uns");
        check_eq("mult_uns_hi_k", Hi, 32'd1);
        check_eq("mult_uns_lo_k", Lo, 32'hFFFFFFFE);
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 0, "div_big");
`endif
        run_op(2'b11, 32'd100, 32'd0, 1'b0, 0, 0, "divu_dz");
        check_eq("divu_dz_hi_k", Hi, 32'd100);
        check_eq("divu_dz_lo_k", Lo, 32'hFFFFFFFF);
        run_op(2'b10, 32'hFFFFFF00, 32'd0, 1'b0, 0, 0, "div_dz");

        run_op(2'b11, 32'd100, 32'd7, 1'b1, 10, 0, "divu_disturb");
        check_eq("divu_disturb_hi_k", Hi, 32'd2);
        check_eq("divu_disturb_lo_k", Lo, 32'd14);

        run_op(2'b11, 32'd100, 32'd7, 1'b0, 0, 15, "divu_rst");

        for (int i = 0; i < 24; i++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 33)), 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
